// File: rtl/mod_delay.sv
// rtl/mod_delay.sv - modulated-delay effect (echo/chorus/flanger) served through smart_ram
// One sample per cs/my_turn grant; a triangle LFO sweeps the read offset for chorus and flanger.
module mod_delay #(
    parameter int DATA_WIDTH  = 16,
    parameter int ADDR_WIDTH  = 12,
    parameter int BASE_OFFSET = 1024,
    parameter int DEPTH       = 256,
    parameter int LFO_DIV     = 16,
    parameter int MIX_SHIFT   = 1,
    parameter int FB_SHIFT    = 1,
    parameter int WR_OFFSET   = 1,
    localparam int LW         = $clog2(DEPTH + 1),
    localparam int CW         = $clog2(LFO_DIV + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cs,
    input  logic                  my_turn,
    input  logic [1:0]            mode,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  available,
    output logic                  done,
    output logic                  sram_rd,
    output logic                  sram_wr,
    output logic [ADDR_WIDTH-1:0] sram_offset,
    output logic [DATA_WIDTH-1:0] sram_data_out,
    input  logic [DATA_WIDTH-1:0] sram_data_in,
    input  logic                  sram_read_finish,
    input  logic                  sram_write_finish,
    output logic [LW-1:0]         lfo_pos
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                  r_state;
    logic [1:0]              r_mode;
    logic [DATA_WIDTH-1:0]   r_data_out;
    logic [DATA_WIDTH-1:0]   r_sram_data_out;
    logic [ADDR_WIDTH-1:0]   r_sram_offset;
    logic                    r_rd;
    logic                    r_wr;
    logic                    r_done;
    logic [LW-1:0]           r_lfo;
    logic                    r_dir_down;
    logic [CW-1:0]           r_cnt;

    logic signed [DATA_WIDTH-1:0] w_wet;
    logic signed [DATA_WIDTH-1:0] w_fb;
    logic signed [DATA_WIDTH:0]   w_mix_sum;
    logic signed [DATA_WIDTH:0]   w_fb_sum;
    logic [ADDR_WIDTH-1:0]        w_mod_offset;

    // Clamp a one-bit-wider sum: overflow shows as disagreeing top two bits.
    function automatic logic [DATA_WIDTH-1:0] sat(input logic signed [DATA_WIDTH:0] s);
        if (s[DATA_WIDTH] != s[DATA_WIDTH-1])
            return s[DATA_WIDTH] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                 : {1'b0, {(DATA_WIDTH-1){1'b1}}};
        else
            return s[DATA_WIDTH-1:0];
    endfunction

    assign w_wet        = $signed(sram_data_in) >>> MIX_SHIFT;
    assign w_fb         = $signed(sram_data_in) >>> FB_SHIFT;
    assign w_mix_sum    = $signed({data_in[DATA_WIDTH-1], data_in}) + $signed({w_wet[DATA_WIDTH-1], w_wet});
    assign w_fb_sum     = $signed({data_in[DATA_WIDTH-1], data_in}) + $signed({w_fb[DATA_WIDTH-1], w_fb});
    assign w_mod_offset = ADDR_WIDTH'(BASE_OFFSET) + ADDR_WIDTH'(r_lfo);

    assign available     = (r_state == S_IDLE);
    assign done          = r_done;
    assign data_out      = r_data_out;
    assign sram_rd       = r_rd;
    assign sram_wr       = r_wr;
    assign sram_offset   = r_sram_offset;
    assign sram_data_out = r_sram_data_out;
    assign lfo_pos       = r_lfo;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state         <= S_IDLE;
            r_mode          <= 2'd0;
            r_data_out      <= '0;
            r_sram_data_out <= '0;
            r_sram_offset   <= '0;
            r_rd            <= 1'b0;
            r_wr            <= 1'b0;
            r_done          <= 1'b0;
            r_lfo           <= '0;
            r_dir_down      <= 1'b0;
            r_cnt           <= '0;
        end else begin
            r_rd   <= 1'b0;
            r_wr   <= 1'b0;
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (cs && my_turn) begin
                        r_mode <= mode;
                        if (mode == 2'd0) begin
                            r_data_out <= data_in;
                            r_done     <= 1'b1;
                            r_state    <= S_DONE;
                        end else begin
                            r_sram_offset <= (mode == 2'd1) ? ADDR_WIDTH'(BASE_OFFSET) : w_mod_offset;
                            r_rd          <= 1'b1;
                            r_state       <= S_READ;
                        end
                    end
                end
                S_READ: begin
                    if (sram_read_finish) begin
                        r_data_out <= sat(w_mix_sum);
                        // Echo (1) and flanger (3) both feed back; chorus (2) does not.
                        if (r_mode[0]) begin
                            r_sram_data_out <= sat(w_fb_sum);
                            r_sram_offset   <= ADDR_WIDTH'(WR_OFFSET);
                            r_wr            <= 1'b1;
                            r_state         <= S_WRITE;
                        end else begin
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end
                    end
                end
                S_WRITE: begin
                    if (sram_write_finish) begin
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    if (r_cnt == CW'(LFO_DIV - 1)) begin
                        r_cnt <= '0;
                        if (!r_dir_down) begin
                            r_lfo <= r_lfo + 1'b1;
                            if (r_lfo == LW'(DEPTH - 1)) r_dir_down <= 1'b1;
                        end else begin
                            r_lfo <= r_lfo - 1'b1;
                            if (r_lfo == LW'(1)) r_dir_down <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mod_delay.sv
// tb/tb_mod_delay.sv - directed self-checking bench for mod_delay
// Two instances share stimulus in lockstep; they differ only in FB_SHIFT (1 vs 2).
module tb_mod_delay;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cs = 1'b0;
    logic        my_turn = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [15:0] data_in = 16'h0;
    logic [15:0] sram_data_in = 16'h0;
    logic        sram_read_finish = 1'b0;
    logic        sram_write_finish = 1'b0;

    logic [15:0] data_out_a, data_out_b, sram_data_out_a, sram_data_out_b;
    logic [11:0] sram_offset_a, sram_offset_b;
    logic        available_a, available_b, done_a, done_b;
    logic        sram_rd_a, sram_rd_b, sram_wr_a, sram_wr_b;
    logic [2:0]  lfo_pos_a, lfo_pos_b;

    int total = 0;
    int bad = 0;

    int          rd_cnt, wr_cnt, done_cnt, done_iter, fin_iter;
    logic        avail_low, post_avail;
    logic [11:0] rd_off, wr_off;
    logic [15:0] wr_data_a, wr_data_b, dout_a, dout_b;

    always #5 clk = ~clk;

    mod_delay #(.DEPTH(4), .LFO_DIV(1), .MIX_SHIFT(1), .FB_SHIFT(1)) dut_a (
        .clk(clk), .rst(rst), .cs(cs), .my_turn(my_turn), .mode(mode), .data_in(data_in),
        .data_out(data_out_a), .available(available_a), .done(done_a),
        .sram_rd(sram_rd_a), .sram_wr(sram_wr_a), .sram_offset(sram_offset_a),
        .sram_data_out(sram_data_out_a), .sram_data_in(sram_data_in),
        .sram_read_finish(sram_read_finish), .sram_write_finish(sram_write_finish),
        .lfo_pos(lfo_pos_a));

    mod_delay #(.DEPTH(4), .LFO_DIV(1), .MIX_SHIFT(1), .FB_SHIFT(2)) dut_b (
        .clk(clk), .rst(rst), .cs(cs), .my_turn(my_turn), .mode(mode), .data_in(data_in),
        .data_out(data_out_b), .available(available_b), .done(done_b),
        .sram_rd(sram_rd_b), .sram_wr(sram_wr_b), .sram_offset(sram_offset_b),
        .sram_data_out(sram_data_out_b), .sram_data_in(sram_data_in),
        .sram_read_finish(sram_read_finish), .sram_write_finish(sram_write_finish),
        .lfo_pos(lfo_pos_b));

    // Plays the master and smart_ram for one sample; records what the DUT did.
    task automatic run_txn(input logic [1:0] m, input logic [15:0] din, input logic [15:0] rdata,
                           input int wdelay);
        int wtimer;
        wtimer = -1;
        rd_cnt = 0; wr_cnt = 0; done_cnt = 0; done_iter = 0; fin_iter = 0; avail_low = 1'b1;
        @(posedge clk); #1;
        cs = 1'b1; my_turn = 1'b1; mode = m; data_in = din;
        for (int it = 1; it <= 40 && done_iter == 0; it++) begin
            @(posedge clk); #1;
            cs = 1'b0; my_turn = 1'b0;
            sram_read_finish = 1'b0; sram_write_finish = 1'b0;
            if (available_a) avail_low = 1'b0;
            if (sram_rd_a) begin
                rd_cnt++; rd_off = sram_offset_a;
                sram_data_in = rdata; sram_read_finish = 1'b1;
            end
            if (sram_wr_a) begin
                wr_cnt++; wr_off = sram_offset_a;
                wr_data_a = sram_data_out_a; wr_data_b = sram_data_out_b;
                wtimer = wdelay;
            end
            if (wtimer == 0) begin sram_write_finish = 1'b1; fin_iter = it; end
            if (wtimer >= 0) wtimer--;
            if (done_a) begin
                done_cnt++; done_iter = it; dout_a = data_out_a; dout_b = data_out_b;
            end
        end
        @(posedge clk); #1;
        sram_read_finish = 1'b0; sram_write_finish = 1'b0;
        if (done_a) done_cnt++;
        post_avail = available_a;
    endtask

    task automatic test_reset;
        #3;
        total++; if (available_a !== 1'b1) begin bad++; $display("FAIL reset_available got=%b exp=1", available_a); end
        total++; if (done_a !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done_a); end
        total++; if (data_out_a !== 16'h0) begin bad++; $display("FAIL reset_data_out got=%h exp=0000", data_out_a); end
        total++; if ({sram_rd_a, sram_wr_a} !== 2'b00) begin bad++; $display("FAIL reset_req got=%b exp=00", {sram_rd_a, sram_wr_a}); end
        total++; if (sram_offset_a !== 12'h0) begin bad++; $display("FAIL reset_offset got=%h exp=000", sram_offset_a); end
        total++; if (sram_data_out_a !== 16'h0) begin bad++; $display("FAIL reset_wdata got=%h exp=0000", sram_data_out_a); end
        total++; if (lfo_pos_a !== 3'd0) begin bad++; $display("FAIL reset_lfo got=%0d exp=0", lfo_pos_a); end
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        total++; if (available_a !== 1'b1) begin bad++; $display("FAIL release_available got=%b exp=1", available_a); end
    endtask

    task automatic test_echo;
        run_txn(2'd1, 16'h1000, 16'h0800, 0);
        total++; if (rd_off !== 12'd1024) begin bad++; $display("FAIL echo_rd_off got=%0d exp=1024", rd_off); end
        total++; if (dout_a !== 16'h1400) begin bad++; $display("FAIL echo_dout got=%h exp=1400", dout_a); end
        total++; if (wr_data_a !== 16'h1400) begin bad++; $display("FAIL echo_wdata got=%h exp=1400", wr_data_a); end
        total++; if (wr_off !== 12'd1) begin bad++; $display("FAIL echo_wr_off got=%0d exp=1", wr_off); end
        total++; if (done_cnt !== 1) begin bad++; $display("FAIL echo_done_cnt got=%0d exp=1", done_cnt); end
        total++; if (done_iter !== 3) begin bad++; $display("FAIL echo_latency got=%0d exp=3", done_iter); end
        total++; if (rd_cnt !== 1 || wr_cnt !== 1) begin bad++; $display("FAIL echo_req_cnt got=%0d/%0d exp=1/1", rd_cnt, wr_cnt); end
    endtask

    task automatic test_saturation;
        run_txn(2'd2, 16'h7000, 16'h7000, 0);
        total++; if (dout_a !== 16'h7FFF) begin bad++; $display("FAIL sat_pos got=%h exp=7fff", dout_a); end
        total++; if (done_iter !== 2) begin bad++; $display("FAIL chorus_latency got=%0d exp=2", done_iter); end
        run_txn(2'd2, 16'h8000, 16'h8000, 0);
        total++; if (dout_a !== 16'h8000) begin bad++; $display("FAIL sat_neg got=%h exp=8000", dout_a); end
    endtask

    task automatic test_reset_in_write;
        total++; if (lfo_pos_a !== 3'd3) begin bad++; $display("FAIL lfo_before_rst got=%0d exp=3", lfo_pos_a); end
        @(posedge clk); #1;
        cs = 1'b1; my_turn = 1'b1; mode = 2'd3; data_in = 16'h0100;
        @(posedge clk); #1;
        cs = 1'b0; my_turn = 1'b0; sram_data_in = 16'h0400; sram_read_finish = 1'b1;
        @(posedge clk); #1;
        sram_read_finish = 1'b0;
        total++; if (sram_wr_a !== 1'b1) begin bad++; $display("FAIL rstw_in_write got=%b exp=1", sram_wr_a); end
        #2 rst = 1'b1;
        #1;
        total++; if (sram_wr_a !== 1'b0) begin bad++; $display("FAIL rstw_wr got=%b exp=0", sram_wr_a); end
        total++; if (available_a !== 1'b1) begin bad++; $display("FAIL rstw_available got=%b exp=1", available_a); end
        total++; if (lfo_pos_a !== 3'd0) begin bad++; $display("FAIL rstw_lfo got=%0d exp=0", lfo_pos_a); end
        total++; if (sram_offset_a !== 12'd0 || data_out_a !== 16'h0) begin bad++; $display("FAIL rstw_regs got=%h/%h exp=000/0000", sram_offset_a, data_out_a); end
        @(negedge clk); rst = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            sram_write_finish = (i == 0);
            if (done_a) done_cnt++;
        end
        sram_write_finish = 1'b0;
        total++; if (done_cnt !== 0) begin bad++; $display("FAIL rstw_no_done got=%0d exp=0", done_cnt); end
        total++; if (available_a !== 1'b1) begin bad++; $display("FAIL rstw_idle got=%b exp=1", available_a); end
    endtask

    task automatic test_chorus_sweep;
        int exp_off [10] = '{1024, 1025, 1026, 1027, 1028, 1027, 1026, 1025, 1024, 1025};
        int wr_total;
        wr_total = 0;
        for (int i = 0; i < 10; i++) begin
            run_txn(2'd2, 16'h0100, 16'h0000, 0);
            wr_total += wr_cnt;
            total++; if (rd_off !== 12'(exp_off[i])) begin bad++; $display("FAIL chorus_off[%0d] got=%0d exp=%0d", i, rd_off, exp_off[i]); end
        end
        total++; if (wr_total !== 0) begin bad++; $display("FAIL chorus_no_wr got=%0d exp=0", wr_total); end
    endtask

    task automatic test_flanger;
        run_txn(2'd3, 16'h0100, 16'h0400, 5);
        total++; if (rd_off !== 12'd1026) begin bad++; $display("FAIL flanger_rd_off got=%0d exp=1026", rd_off); end
        total++; if (wr_data_b !== 16'h0200) begin bad++; $display("FAIL flanger_wdata got=%h exp=0200", wr_data_b); end
        total++; if (dout_b !== 16'h0300) begin bad++; $display("FAIL flanger_dout got=%h exp=0300", dout_b); end
        total++; if (fin_iter !== 7 || done_iter !== 8) begin bad++; $display("FAIL flanger_timing got=%0d/%0d exp=7/8", fin_iter, done_iter); end
        total++; if (done_cnt !== 1) begin bad++; $display("FAIL flanger_done_cnt got=%0d exp=1", done_cnt); end
    endtask

    task automatic test_bypass;
        logic [2:0] lfo_before;
        lfo_before = lfo_pos_a;
        run_txn(2'd0, 16'h1234, 16'hFFFF, 0);
        total++; if (dout_a !== 16'h1234) begin bad++; $display("FAIL bypass_dout got=%h exp=1234", dout_a); end
        total++; if (done_iter !== 1) begin bad++; $display("FAIL bypass_latency got=%0d exp=1", done_iter); end
        total++; if (rd_cnt !== 0) begin bad++; $display("FAIL bypass_no_rd got=%0d exp=0", rd_cnt); end
        total++; if (avail_low !== 1'b1 || post_avail !== 1'b1) begin bad++; $display("FAIL bypass_available got=%b/%b exp=1/1", avail_low, post_avail); end
        total++; if (lfo_before !== 3'd3 || lfo_pos_a !== 3'd4) begin bad++; $display("FAIL bypass_lfo got=%0d->%0d exp=3->4", lfo_before, lfo_pos_a); end
    endtask

    initial begin
        test_reset;
        test_echo;
        test_saturation;
        test_reset_in_write;
        test_chorus_sweep;
        test_flanger;
        test_bypass;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mod_delay.md
# mod_delay

Parametrised modulated-delay effect: echo, chorus and flanger in one block. It sits in the effects chain beside the other smart_ram clients and processes one audio sample per `cs`/`my_turn` grant. Each sample is mixed with a delayed sample fetched from smart_ram at an offset swept by an internal triangle LFO. Feedback is optional, all sums saturate, and a bypass mode is provided.

## Interface
- `DATA_WIDTH`, 16: signed sample width (two's complement).
- `ADDR_WIDTH`, 12: smart_ram offset width.
- `BASE_OFFSET`, 1024: minimum delay offset. Require `BASE_OFFSET + DEPTH < 2**ADDR_WIDTH`.
- `DEPTH`, 256: LFO sweep amplitude in offset steps (≥1).
- `LFO_DIV`, 16: completed samples per LFO step (≥1).
- `MIX_SHIFT`, 1: wet attenuation, arithmetic right shift.
- `FB_SHIFT`, 1: feedback attenuation, arithmetic right shift.
- `WR_OFFSET`, 1: offset written in feedback modes.

Ports:
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: reset, **asynchronous, active-high**.
- `cs` in 1: block selected.
- `my_turn` in 1: sample slot granted to this block.
- `mode` in 2: 0 bypass, 1 echo (fixed offset, feedback), 2 chorus (modulated, no feedback), 3 flanger (modulated, feedback). Sampled at accept.
- `data_in` in DATA_WIDTH: dry sample. Held stable by the master until `done`.
- `data_out` out DATA_WIDTH: processed sample, registered.
- `available` out 1: high in IDLE.
- `done` out 1: one-cycle completion pulse.
- `sram_rd` out 1: one-cycle read request.
- `sram_wr` out 1: one-cycle write request.
- `sram_offset` out ADDR_WIDTH: request offset, registered.
- `sram_data_out` out DATA_WIDTH: write data, registered.
- `sram_data_in` in DATA_WIDTH: read data, valid while `sram_read_finish` is high.
- `sram_read_finish` in 1: read complete.
- `sram_write_finish` in 1: write complete.
- `lfo_pos` out ceil(log2(DEPTH+1)): current LFO position, for debug.

## Operation
- States are IDLE, READ, WRITE and DONE.
- **IDLE:** if `cs & my_turn`, latch `mode`.
  - Mode 0: `data_out <= data_in`, go to DONE. No smart_ram access.
  - Modes 1–3: `sram_offset <= BASE_OFFSET` (mode 1) or `BASE_OFFSET + lfo_pos` (modes 2, 3). Pulse `sram_rd`, go to READ.
- **READ:** wait for `sram_read_finish`.
  - On finish: `wet = sram_data_in >>> MIX_SHIFT` and `data_out <= sat(data_in + wet)`.
  - Modes 1 and 3: `sram_data_out <= sat(data_in + (sram_data_in >>> FB_SHIFT))`, `sram_offset <= WR_OFFSET`, pulse `sram_wr`, go to WRITE.
  - Mode 2: go to DONE.
- **WRITE:** wait for `sram_write_finish`, then go to DONE.
- **DONE:** `done = 1` for exactly one cycle, then IDLE. The sample counter increments here.
- **Arithmetic:** sums are formed at DATA_WIDTH+1 bits and `sat()` clamps to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1]. There is no wrap-around.
- **LFO:**
  - When the sample counter reaches LFO_DIV, it clears and `lfo_pos` steps by ±1 in the current direction.
  - Direction reverses on reaching DEPTH (going up) or 0 (going down), so the sequence for DEPTH=2 is 0,1,2,1,0,1…
  - The LFO runs in every mode, including bypass.
- `cs`/`my_turn` outside IDLE are ignored. There is no queuing.

## Timing
- **Reset values:** state IDLE, `available`=1, `done`=0, `data_out`=0, `sram_rd`=0, `sram_wr`=0, `sram_offset`=0, `sram_data_out`=0, `lfo_pos`=0, direction up, sample counter 0.
- **Reset mid-operation:** any state returns to IDLE immediately. Pending requests drop and no `done` is issued. The LFO restarts.
- **Request pulses:** `sram_rd` and `sram_wr` are high for exactly the first cycle of READ and WRITE. `sram_offset` is stable from that cycle until the state is left.
- **Finish inputs:** a finish is accepted on any cycle in READ/WRITE, including the request cycle. Finish inputs are ignored in other states.
- **Latency from accept edge T0** (finish returned at earliest):
  - Bypass: `done` at T1.
  - Chorus: `done` at T2.
  - Echo/flanger: `done` at T3.
- `data_out` is valid from the cycle `done` is high and holds until the next finish or bypass accept.
- `available` is combinational from state. It is low from T1 until the cycle after `done`.

## Test plan
- **Reset:** assert `rst` asynchronously mid-cycle → all outputs reach reset values before the next edge. After release, `available`=1.
- **Echo, MIX_SHIFT=FB_SHIFT=1:** `data_in`=0x1000, `sram_data_in`=0x0800 → read at offset 1024, `data_out`=0x1400, write 0x1400 at offset 1, one `done`.
- **Saturation:**
  - 0x7000 + 0x7000 → `data_out`=0x7FFF.
  - 0x8000 + 0x8000 → `data_out`=0x8000.
- **Chorus, DEPTH=4, LFO_DIV=1:** 10 consecutive samples → read offsets 1024,1025,1026,1027,1028,1027,1026,1025,1024,1025. No `sram_wr` is ever asserted.
- **Flanger, FB_SHIFT=2:** `data_in`=0x0100, `sram_data_in`=0x0400 → write 0x0200. `sram_write_finish` is delayed 5 cycles → `done` comes 1 cycle after the finish, with `data_out`=0x0300.
- **Robustness:**
  - Bypass `data_in`=0x1234 → `data_out`=0x1234 with `done` at T1 and no `sram_rd`.
  - `rst` asserted during WRITE → no `done`, returns to IDLE with `lfo_pos`=0.
